// File: rtl/msrv32_dmem_responder.sv
// Word-organised data-memory responder: byte-masked writes, full-word reads, WAIT_CYCLES wait states.
// Optional address bounds checking is enabled with `define MSRV32_DMEM_BOUNDS_EN.
module msrv32_dmem_responder #(
    parameter int DEPTH       = 1024,
    parameter int WAIT_CYCLES = 0
) (
    input  logic        ms_riscv32_mp_clk_in,
    input  logic        ms_riscv32_mp_rst_in,
    input  logic        dmem_req_in,
    input  logic        dmem_wr_in,
    input  logic [31:0] dmem_addr_in,
    input  logic [31:0] dmem_wdata_in,
    input  logic [3:0]  dmem_wr_mask_in,
    output logic        dmem_ack_out,
    output logic [31:0] dmem_rdata_out,
    output logic        dmem_err_out,
    output logic        dmem_busy_out
);
    localparam int         IDX_W     = $clog2(DEPTH);
    localparam logic [3:0] WAIT_INIT = 4'(WAIT_CYCLES);

    typedef enum logic [1:0] {S_IDLE, S_WAIT, S_ACK} state_t;

    state_t      state_q;
    logic [3:0]  cnt_q;
    logic        wr_q;
    logic [31:0] addr_q;
    logic [31:0] wdata_q;
    logic [3:0]  mask_q;
    logic [31:0] mem_q [DEPTH];

    logic             acc_en;
    logic             acc_wr;
    logic             acc_oob;
    logic [31:0]      acc_addr;
    logic [31:0]      acc_wdata;
    logic [3:0]       acc_mask;
    logic [IDX_W-1:0] acc_idx;
    logic             unused_addr;

    // With zero wait states the access happens on the capture edge itself,
    // so the live inputs are used instead of the captured copies.
    always_comb begin
        acc_wr    = wr_q;
        acc_addr  = addr_q;
        acc_wdata = wdata_q;
        acc_mask  = mask_q;
        if (state_q == S_IDLE) begin
            acc_wr    = dmem_wr_in;
            acc_addr  = dmem_addr_in;
            acc_wdata = dmem_wdata_in;
            acc_mask  = dmem_wr_mask_in;
        end
        acc_en = !ms_riscv32_mp_rst_in &&
                 (((state_q == S_IDLE) && dmem_req_in && (WAIT_CYCLES == 0)) ||
                  ((state_q == S_WAIT) && (cnt_q == 4'd1)));
    end

    assign acc_idx     = acc_addr[IDX_W+1:2];
    assign unused_addr = ^{acc_addr[1:0], acc_addr[31:IDX_W+2]};

`ifdef MSRV32_DMEM_BOUNDS_EN
    assign acc_oob = (acc_addr >> (IDX_W + 2)) != 32'd0;
`else
    assign acc_oob = 1'b0;
`endif

    always_ff @(posedge ms_riscv32_mp_clk_in or posedge ms_riscv32_mp_rst_in) begin
        if (ms_riscv32_mp_rst_in) begin
            state_q        <= S_IDLE;
            cnt_q          <= 4'd0;
            wr_q           <= 1'b0;
            addr_q         <= 32'd0;
            wdata_q        <= 32'd0;
            mask_q         <= 4'd0;
            dmem_ack_out   <= 1'b0;
            dmem_rdata_out <= 32'd0;
            dmem_err_out   <= 1'b0;
            dmem_busy_out  <= 1'b0;
        end else begin
            dmem_ack_out <= 1'b0;
            if (acc_en) begin
                dmem_ack_out <= 1'b1;
                dmem_err_out <= acc_oob;
                if (!acc_wr)
                    dmem_rdata_out <= acc_oob ? 32'd0 : mem_q[acc_idx];
            end
            case (state_q)
                S_IDLE: begin
                    if (dmem_req_in) begin
                        wr_q          <= dmem_wr_in;
                        addr_q        <= dmem_addr_in;
                        wdata_q       <= dmem_wdata_in;
                        mask_q        <= dmem_wr_mask_in;
                        cnt_q         <= WAIT_INIT;
                        dmem_busy_out <= 1'b1;
                        state_q       <= (WAIT_CYCLES == 0) ? S_ACK : S_WAIT;
                    end
                end
                S_WAIT: begin
                    cnt_q <= cnt_q - 4'd1;
                    if (cnt_q == 4'd1)
                        state_q <= S_ACK;
                end
                default: begin
                    state_q       <= S_IDLE;
                    dmem_busy_out <= 1'b0;
                end
            endcase
        end
    end

    // Array is deliberately outside the reset domain; contents survive reset.
    always_ff @(posedge ms_riscv32_mp_clk_in) begin
        if (acc_en && acc_wr && !acc_oob) begin
            for (int i = 0; i < 4; i++)
                if (acc_mask[i])
                    mem_q[acc_idx][8*i +: 8] <= acc_wdata[8*i +: 8];
        end
    end
endmodule

// File: tb/tb_msrv32_dmem_responder.sv
// Bench for msrv32_dmem_responder: two instances (0 and 3 wait states), vector table,
// directed multi-cycle sequences and a randomized run against a byte-level memory model.
module tb_msrv32_dmem_responder;
    localparam int DEPTH = 1024;
`ifdef MSRV32_DMEM_BOUNDS_EN
    localparam bit BND = 1'b1;
`else
    localparam bit BND = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        req   [2];
    logic        wr    [2];
    logic [31:0] addr  [2];
    logic [31:0] wdata [2];
    logic [3:0]  mask  [2];
    logic        ack   [2];
    logic [31:0] rdata [2];
    logic        err   [2];
    logic        busy  [2];

    int compared = 0;
    int mismatched = 0;
    logic [31:0] last_rd [2];
    logic [7:0]  refm [int];

    always #5 clk = ~clk;

    msrv32_dmem_responder #(.DEPTH(DEPTH), .WAIT_CYCLES(0)) u_dut0 (
        .ms_riscv32_mp_clk_in(clk), .ms_riscv32_mp_rst_in(rst),
        .dmem_req_in(req[0]), .dmem_wr_in(wr[0]), .dmem_addr_in(addr[0]),
        .dmem_wdata_in(wdata[0]), .dmem_wr_mask_in(mask[0]),
        .dmem_ack_out(ack[0]), .dmem_rdata_out(rdata[0]),
        .dmem_err_out(err[0]), .dmem_busy_out(busy[0]));

    msrv32_dmem_responder #(.DEPTH(DEPTH), .WAIT_CYCLES(3)) u_dut3 (
        .ms_riscv32_mp_clk_in(clk), .ms_riscv32_mp_rst_in(rst),
        .dmem_req_in(req[1]), .dmem_wr_in(wr[1]), .dmem_addr_in(addr[1]),
        .dmem_wdata_in(wdata[1]), .dmem_wr_mask_in(mask[1]),
        .dmem_ack_out(ack[1]), .dmem_rdata_out(rdata[1]),
        .dmem_err_out(err[1]), .dmem_busy_out(busy[1]));

    function automatic int wait_of(input int d);
        return (d == 0) ? 0 : 3;
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        compared++;
        if (act !== exp) begin
            mismatched++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", nm, act, exp);
        end
    endtask

    task automatic txn(input int d, input logic w, input logic [31:0] a, input logic [31:0] wd,
                       input logic [3:0] m, output logic [31:0] rd, output logic er,
                       output int lat, output int bc);
        @(negedge clk);
        req[d] = 1'b1; wr[d] = w; addr[d] = a; wdata[d] = wd; mask[d] = m;
        @(posedge clk);
        #1;
        req[d] = 1'b0; wr[d] = 1'($urandom); addr[d] = $urandom;
        wdata[d] = $urandom; mask[d] = 4'($urandom);
        lat = 0; bc = 0; rd = 32'hx; er = 1'bx;
        for (int c = 1; c <= 40; c++) begin
            @(negedge clk);
            if (busy[d]) bc++;
            if (ack[d]) begin
                lat = c; rd = rdata[d]; er = err[d];
                break;
            end
        end
    endtask

    task automatic run(input int d, input logic w, input logic [31:0] a, input logic [31:0] wd,
                       input logic [3:0] m, input logic [31:0] erd, input logic eerr,
                       input string nm);
        logic [31:0] rd;
        logic er;
        int lat, bc;
        txn(d, w, a, wd, m, rd, er, lat, bc);
        chk({nm, "_latency"}, 32'(lat), 32'(wait_of(d) + 1));
        chk({nm, "_busy_cycles"}, 32'(bc), 32'(wait_of(d) + 1));
        chk({nm, "_rdata"}, rd, erd);
        chk({nm, "_err"}, {31'd0, er}, {31'd0, eerr});
        last_rd[d] = erd;
    endtask

    // Byte-addressed reference memory; out-of-range handling from the address rules.
    task automatic mtx(input int d, input logic w, input logic [31:0] a, input logic [31:0] wd,
                       input logic [3:0] m, input string nm);
        bit oob;
        int base;
        logic [31:0] erd;
        oob  = BND && (a >= 32'(DEPTH * 4));
        base = d * 32'h10_0000 + int'((a / 4) % DEPTH) * 4;
        erd  = last_rd[d];
        if (w) begin
            if (!oob)
                for (int i = 0; i < 4; i++)
                    if (m[i]) refm[base + i] = wd[8*i +: 8];
        end else if (oob) begin
            erd = 32'd0;
        end else begin
            for (int i = 0; i < 4; i++)
                erd[8*i +: 8] = refm.exists(base + i) ? refm[base + i] : 8'hxx;
        end
        run(d, w, a, wd, m, erd, oob, nm);
    endtask

    task automatic b2b(input int d, input logic [31:0] a0, input logic [31:0] e0,
                       input logic [31:0] a1, input logic [31:0] e1, input string nm);
        int last, n;
        last = -1; n = 0;
        @(negedge clk);
        req[d] = 1'b1; wr[d] = 1'b0; addr[d] = a0; mask[d] = 4'($urandom);
        for (int c = 0; c < 60; c++) begin
            @(negedge clk);
            if (ack[d]) begin
                chk({nm, "_rdata"}, rdata[d], (n % 2 == 0) ? e0 : e1);
                if (n > 0) chk({nm, "_spacing"}, 32'(c - last), 32'(wait_of(d) + 2));
                last = c;
                n++;
                addr[d] = (n % 2 == 1) ? a1 : a0;
                if (n == 4) begin
                    req[d] = 1'b0;
                    break;
                end
            end
        end
        chk({nm, "_ack_count"}, 32'(n), 32'd4);
        req[d] = 1'b0;
        for (int c = 0; c < 6; c++) begin
            @(negedge clk);
            chk({nm, "_no_extra_ack"}, {31'd0, ack[d]}, 32'd0);
        end
        last_rd[d] = e1;
    endtask

    typedef struct {
        logic        w;
        logic [31:0] a;
        logic [31:0] wd;
        logic [3:0]  m;
        logic [31:0] erd;
        logic        eerr;
    } vec_t;

    vec_t tbl [10];

    initial begin
        for (int d = 0; d < 2; d++) begin
            req[d] = 0; wr[d] = 0; addr[d] = 0; wdata[d] = 0; mask[d] = 0; last_rd[d] = 0;
        end

        tbl[0] = '{1'b1, 32'h0000_0000, 32'h0BAD_C0DE, 4'hF, 32'h0, 1'b0};
        tbl[1] = '{1'b1, 32'h0000_0010, 32'hDEAD_BEEF, 4'hF, 32'h0, 1'b0};
        tbl[2] = '{1'b0, 32'h0000_0010, 32'h0,         4'h0, 32'hDEAD_BEEF, 1'b0};
        tbl[3] = '{1'b1, 32'h0000_0010, 32'h1122_3344, 4'h5, 32'hDEAD_BEEF, 1'b0};
        tbl[4] = '{1'b0, 32'h0000_0010, 32'h0,         4'hF, 32'hDE22_BE44, 1'b0};
        tbl[5] = '{1'b1, 32'h0000_0010, 32'hFFFF_FFFF, 4'h0, 32'hDE22_BE44, 1'b0};
        tbl[6] = '{1'b0, 32'h0000_0010, 32'h0,         4'h0, 32'hDE22_BE44, 1'b0};
        tbl[7] = '{1'b1, 32'h0000_1000, 32'hCAFE_F00D, 4'hF, 32'hDE22_BE44, BND};
        tbl[8] = '{1'b0, 32'h0000_0000, 32'h0,         4'h0,
                   BND ? 32'h0BAD_C0DE : 32'hCAFE_F00D, 1'b0};
        tbl[9] = '{1'b0, 32'h0000_0013, 32'h0,         4'h0, 32'hDE22_BE44, 1'b0};

        // Reset state
        #12;
        for (int d = 0; d < 2; d++) begin
            chk("reset_ack",   {31'd0, ack[d]},  32'd0);
            chk("reset_rdata", rdata[d],         32'd0);
            chk("reset_err",   {31'd0, err[d]},  32'd0);
            chk("reset_busy",  {31'd0, busy[d]}, 32'd0);
        end
        @(negedge clk);
        rst = 1'b0;

        for (int i = 0; i < 10; i++)
            run(0, tbl[i].w, tbl[i].a, tbl[i].wd, tbl[i].m, tbl[i].erd, tbl[i].eerr,
                $sformatf("vec%0d", i));

        // Seed the three-wait-state instance
        run(1, 1'b1, 32'h10, 32'hDEAD_BEEF, 4'hF, 32'h0, 1'b0, "w3_wr10");
        run(1, 1'b1, 32'h14, 32'h1414_1414, 4'hF, 32'h0, 1'b0, "w3_wr14");
        run(1, 1'b1, 32'h20, 32'h1111_1111, 4'hF, 32'h0, 1'b0, "w3_wr20");

        // Read with request toggling during the wait states
        @(negedge clk);
        req[1] = 1'b1; wr[1] = 1'b0; addr[1] = 32'h10;
        @(posedge clk);
        #1;
        req[1] = 1'b0;
        for (int c = 1; c <= 4; c++) begin
            @(negedge clk);
            chk($sformatf("toggle_ack_c%0d", c), {31'd0, ack[1]}, {31'd0, c == 4});
            chk($sformatf("toggle_busy_c%0d", c), {31'd0, busy[1]}, 32'd1);
            wr[1] = 1'b1; addr[1] = 32'h10; wdata[1] = 32'h0; mask[1] = 4'hF;
            req[1] = (c == 1 || c == 3);
        end
        chk("toggle_rdata", rdata[1], 32'hDEAD_BEEF);
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            chk("toggle_no_ack",  {31'd0, ack[1]},  32'd0);
            chk("toggle_no_busy", {31'd0, busy[1]}, 32'd0);
        end
        run(1, 1'b0, 32'h10, 32'h0, 4'h0, 32'hDEAD_BEEF, 1'b0, "toggle_reread");

        // Reset in the middle of a pending write
        @(negedge clk);
        req[1] = 1'b1; wr[1] = 1'b1; addr[1] = 32'h20; wdata[1] = 32'h55AA_55AA; mask[1] = 4'hF;
        @(posedge clk);
        #1;
        req[1] = 1'b0;
        @(negedge clk);
        #2 rst = 1'b1;
        #1;
        chk("rst_wait_busy",  {31'd0, busy[1]}, 32'd0);
        chk("rst_wait_rdata", rdata[1],         32'd0);
        chk("rst_wait_ack",   {31'd0, ack[1]},  32'd0);
        chk("rst_dut0_rdata", rdata[0],         32'd0);
        @(negedge clk);
        rst = 1'b0;
        last_rd[0] = 32'd0; last_rd[1] = 32'd0;
        for (int c = 0; c < 6; c++) begin
            @(negedge clk);
            chk("rst_no_ack", {31'd0, ack[1]}, 32'd0);
        end
        run(1, 1'b0, 32'h20, 32'h0, 4'h0, 32'h1111_1111, 1'b0, "rst_preserved");

        // Back-to-back with request held high
        b2b(1, 32'h10, 32'hDEAD_BEEF, 32'h14, 32'h1414_1414, "b2b_w3");
        b2b(0, 32'h10, 32'hDE22_BE44, 32'h0, BND ? 32'h0BAD_C0DE : 32'hCAFE_F00D, "b2b_w0");

        // Randomized traffic against the byte model
        for (int d = 0; d < 2; d++) begin
            for (int k = 0; k < 8; k++)
                mtx(d, 1'b1, 32'h100 + 32'(4 * k), $urandom, 4'hF, "rand_init");
            for (int n = 0; n < 60; n++) begin
                int k, sel;
                logic [31:0] a;
                k   = $urandom_range(0, 7);
                sel = $urandom_range(0, 5);
                if (sel == 0)      a = 32'h0000_1100 + 32'(4 * k);
                else if (sel == 1) a = 32'h8000_0100 + 32'(4 * k);
                else               a = 32'h100 + 32'(4 * k) + 32'($urandom_range(0, 3));
                mtx(d, 1'($urandom_range(0, 1)), a, $urandom, 4'($urandom_range(0, 15)),
                    $sformatf("rand_d%0d_n%0d", d, n));
            end
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end
endmodule
